mem_access_unit: RTL

- Memory-stage consumer of the decode control word (MemRead, MemWrite, MemToReg path).
- Executes LW/SW directly and LB/LH/SB/SH safely against a word-wide data memory with a variable-latency ready handshake. Sub-word stores use read-modify-write.
- Stalls the pipeline while an access is in flight and returns aligned, extended load data to write-back.

---
 rtl/mem_access_unit_if.sv | 41 ++++
 rtl/mem_access_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline-side and memory-side bundles for mem_access_unit
interface mem_access_unit_pipe_if;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        SignedLoad;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        Stall;
    logic        Done;
    logic [31:0] ReadData;
    logic        AddrErr;
    logic        BusErr;

    modport master (
        output MemRead, MemWrite, Size, SignedLoad, Address, WriteData,
        input  Stall, Done, ReadData, AddrErr, BusErr
    );
    modport slave (
        input  MemRead, MemWrite, Size, SignedLoad, Address, WriteData,
        output Stall, Done, ReadData, AddrErr, BusErr
    );
endinterface

interface mem_access_unit_mem_if;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic        MemRe;
    logic        MemWe;
    logic [31:0] MemRData;
    logic        MemReady;

    modport master (
        output MemAddr, MemWData, MemRe, MemWe,
        input  MemRData, MemReady
    );
    modport slave (
        input  MemAddr, MemWData, MemRe, MemWe,
        output MemRData, MemReady
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with sub-word RMW and ready timeout
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                    Clk,
    input  logic                    Rst,
    mem_access_unit_pipe_if.slave   pipe,
    mem_access_unit_mem_if.master   mem
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_WRITE     = 3'd2;
    localparam logic [2:0] S_RMW_READ  = 3'd3;
    localparam logic [2:0] S_RMW_WRITE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_WRD2 = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_lane;
    logic [1:0]       r_size;
    logic             r_signed;
    logic [15:0]      r_wdata;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic             r_mem_re;
    logic             r_mem_we;
    logic             r_done;
    logic [31:0]      r_rdata;
    logic             r_addr_err;
    logic             r_bus_err;

    logic             w_req;
    logic             w_word;
    logic             w_illegal;
    logic             w_phase;
    logic             w_timeout;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic [31:0]      w_merged;

    assign w_req  = pipe.MemRead | pipe.MemWrite;
    assign w_word = (pipe.Size == SZ_WORD) || (pipe.Size == SZ_WRD2);

    assign w_illegal = (pipe.MemRead & pipe.MemWrite)
                     | ((pipe.Size == SZ_HALF) & pipe.Address[0])
                     | (w_word & (pipe.Address[1:0] != 2'b00));

    assign w_phase = (r_state == S_READ) || (r_state == S_WRITE) ||
                     (r_state == S_RMW_READ) || (r_state == S_RMW_WRITE);

    // TIMEOUT == 0 disables the abort; the counter just wraps harmlessly
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    assign pipe.Stall = w_phase || ((r_state == S_IDLE) && w_req);

    assign w_byte = mem.MemRData[{r_lane, 3'b000} +: 8];
    assign w_half = mem.MemRData[{r_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = mem.MemRData;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load_data = mem.MemRData;
        endcase
    end

    // Little-endian lane merge of the latched store data into the fetched word
    always_comb begin
        w_merged = mem.MemRData;
        if (r_size == SZ_BYTE) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_lane      <= 2'b00;
            r_size      <= SZ_WORD;
            r_signed    <= 1'b0;
            r_wdata     <= 16'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_done      <= 1'b0;
            r_rdata     <= 32'h0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_lane   <= pipe.Address[1:0];
                        r_size   <= pipe.Size;
                        r_signed <= pipe.SignedLoad;
                        r_wdata  <= pipe.WriteData[15:0];
                        r_cnt    <= '0;
                        if (w_illegal) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b1;
                            r_bus_err  <= 1'b0;
                            r_rdata    <= 32'h0;
                        end else begin
                            r_mem_addr <= {pipe.Address[31:2], 2'b00};
                            if (pipe.MemRead) begin
                                r_state  <= S_READ;
                                r_mem_re <= 1'b1;
                            end else if (w_word) begin
                                r_state     <= S_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= pipe.WriteData;
                            end else begin
                                r_state  <= S_RMW_READ;
                                r_mem_re <= 1'b1;
                            end
                        end
                    end
                end

                S_READ, S_WRITE, S_RMW_READ, S_RMW_WRITE: begin
                    if (mem.MemReady) begin
                        r_cnt <= '0;
                        if (r_state == S_RMW_READ) begin
                            r_state     <= S_RMW_WRITE;
                            r_mem_re    <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_merged;
                        end else begin
                            r_state    <= S_DONE;
                            r_mem_re   <= 1'b0;
                            r_mem_we   <= 1'b0;
                            r_done     <= 1'b1;
                            r_addr_err <= 1'b0;
                            r_bus_err  <= 1'b0;
                            r_rdata    <= (r_state == S_READ) ? w_load_data : 32'h0;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_DONE;
                        r_mem_re   <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_done     <= 1'b1;
                        r_addr_err <= 1'b0;
                        r_bus_err  <= 1'b1;
                        r_rdata    <= 32'h0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state  <= S_IDLE;
                    r_mem_re <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign pipe.Done     = r_done;
    assign pipe.ReadData = r_rdata;
    assign pipe.AddrErr  = r_addr_err;
    assign pipe.BusErr   = r_bus_err;
    assign mem.MemAddr   = r_mem_addr;
    assign mem.MemWData  = r_mem_wdata;
    assign mem.MemRe     = r_mem_re;
    assign mem.MemWe     = r_mem_we;

endmodule
